vc_input_block: RTL and testbench

Multi-virtual-channel input buffer bank for all router input ports; the next generation of the single-queue-per-port input block. Each of PORT_NUM ports demultiplexes arriving flits into VC_NUM independent FIFOs of BUFFER_SIZE entries. Each port pops one (vc-selected) flit per cycle toward the crossbar under switch-allocator control and returns a per-VC credit upstream. Sits between the link receivers and the crossbar / switch allocator.

---
 rtl/vc_input_block.sv | 184 ++++++++++++++++++
 tb/tb_vc_input_block.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_input_block.sv
// vc_input_block: per-port bank of VC_NUM circular FIFOs (BUFFER_SIZE deep each).
// Arriving flits are steered to the FIFO chosen by vc_i. Each port pops at most
// one flit per cycle toward the crossbar, and every pop returns a credit upstream.
// Define VC_INPUT_BLOCK_OCC_EN to add occ_o, a registered per-VC occupancy output.
module vc_input_block #(
  parameter int PORT_NUM    = 5,
  parameter int VC_NUM      = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int FLIT_W      = 32,
  parameter int VC_W        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int CNT_W       = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORT_NUM*FLIT_W-1:0]    data_i,
  input  logic [PORT_NUM-1:0]           valid_i,
  input  logic [PORT_NUM*VC_W-1:0]      vc_i,
  input  logic [PORT_NUM-1:0]           rd_en_i,
  input  logic [PORT_NUM*VC_W-1:0]      rd_vc_i,
  output logic [PORT_NUM*FLIT_W-1:0]    flit_o,
  output logic [PORT_NUM-1:0]           flit_valid_o,
  output logic [PORT_NUM-1:0]           credit_o,
  output logic [PORT_NUM*VC_W-1:0]      credit_vc_o,
  output logic [PORT_NUM*VC_NUM-1:0]    nonempty_o,
  output logic [PORT_NUM-1:0]           error_o
`ifdef VC_INPUT_BLOCK_OCC_EN
  ,
  output logic [PORT_NUM*VC_NUM*CNT_W-1:0] occ_o
`endif
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam logic [VC_W:0]      VC_LIM = (VC_W + 1)'(VC_NUM);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(BUFFER_SIZE);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(BUFFER_SIZE - 1);

  // Pointer advance with explicit wrap, so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = ptr + PTR_W'(1);
    end
  endfunction

  logic [FLIT_W-1:0] mem_r     [PORT_NUM][VC_NUM][BUFFER_SIZE];
  logic [PTR_W-1:0]  wr_ptr_r  [PORT_NUM][VC_NUM];
  logic [PTR_W-1:0]  rd_ptr_r  [PORT_NUM][VC_NUM];
  logic [CNT_W-1:0]  cnt_r     [PORT_NUM][VC_NUM];
  logic [CNT_W-1:0]  cnt_next_s[PORT_NUM][VC_NUM];

  logic [VC_W-1:0]   push_vc_s [PORT_NUM];
  logic [VC_W-1:0]   pop_vc_s  [PORT_NUM];
  logic [PORT_NUM-1:0] push_vc_ok_s;
  logic [PORT_NUM-1:0] pop_vc_ok_s;
  logic [VC_NUM-1:0] push_req_s [PORT_NUM];
  logic [VC_NUM-1:0] pop_req_s  [PORT_NUM];
  logic [VC_NUM-1:0] push_do_s  [PORT_NUM];
  logic [VC_NUM-1:0] pop_do_s   [PORT_NUM];
  logic [PORT_NUM-1:0] pop_any_s;
  logic [PORT_NUM-1:0] err_s;
  logic [FLIT_W-1:0] head_s [PORT_NUM];

  logic [PORT_NUM*FLIT_W-1:0] flit_r;
  logic [PORT_NUM-1:0]        flit_valid_r;
  logic [PORT_NUM-1:0]        credit_r;
  logic [PORT_NUM*VC_W-1:0]   credit_vc_r;
  logic [PORT_NUM*VC_NUM-1:0] nonempty_r;
  logic [PORT_NUM-1:0]        error_r;

  // Decode the per-port VC selectors and flag indices beyond VC_NUM.
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      push_vc_s[p]    = vc_i[p*VC_W +: VC_W];
      pop_vc_s[p]     = rd_vc_i[p*VC_W +: VC_W];
      push_vc_ok_s[p] = ({1'b0, push_vc_s[p]} < VC_LIM);
      pop_vc_ok_s[p]  = ({1'b0, pop_vc_s[p]} < VC_LIM);
    end
  end

  // Per-VC accept/reject decisions (pre-edge counts), head select, next counts.
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      pop_any_s[p] = 1'b0;
      head_s[p]    = {FLIT_W{1'b0}};
      for (int v = 0; v < VC_NUM; v++) begin
        push_req_s[p][v] = valid_i[p] && push_vc_ok_s[p] && (push_vc_s[p] == VC_W'(v));
        pop_req_s[p][v]  = rd_en_i[p] && pop_vc_ok_s[p] && (pop_vc_s[p] == VC_W'(v));
        // No bypass: an empty VC cannot be popped even with a same-cycle push.
        pop_do_s[p][v]   = pop_req_s[p][v] && (cnt_r[p][v] != {CNT_W{1'b0}});
        // A full VC still accepts a push when the same VC pops this cycle.
        push_do_s[p][v]  = push_req_s[p][v] && ((cnt_r[p][v] != CNT_FULL) || pop_do_s[p][v]);
        if (pop_do_s[p][v]) begin
          pop_any_s[p] = 1'b1;
          head_s[p]    = mem_r[p][v][rd_ptr_r[p][v]];
        end else begin
          pop_any_s[p] = pop_any_s[p];
          head_s[p]    = head_s[p];
        end
        case ({push_do_s[p][v], pop_do_s[p][v]})
          2'b10:   cnt_next_s[p][v] = cnt_r[p][v] + CNT_W'(1);
          2'b01:   cnt_next_s[p][v] = cnt_r[p][v] - CNT_W'(1);
          default: cnt_next_s[p][v] = cnt_r[p][v];
        endcase
      end
      err_s[p] = (valid_i[p] && !push_vc_ok_s[p]) ||
                 (rd_en_i[p] && !pop_vc_ok_s[p]) ||
                 (|(push_req_s[p] & ~push_do_s[p])) ||
                 (|(pop_req_s[p] & ~pop_do_s[p]));
    end
  end

  // Flit storage: written on accepted pushes only, never cleared by reset.
  always_ff @(posedge clk) begin
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (push_do_s[p][v]) begin
          mem_r[p][v][wr_ptr_r[p][v]] <= data_i[p*FLIT_W +: FLIT_W];
        end
      end
    end
  end

  // FIFO pointers, counts and all registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          wr_ptr_r[p][v] <= {PTR_W{1'b0}};
          rd_ptr_r[p][v] <= {PTR_W{1'b0}};
          cnt_r[p][v]    <= {CNT_W{1'b0}};
        end
      end
      flit_r       <= {(PORT_NUM*FLIT_W){1'b0}};
      flit_valid_r <= {PORT_NUM{1'b0}};
      credit_r     <= {PORT_NUM{1'b0}};
      credit_vc_r  <= {(PORT_NUM*VC_W){1'b0}};
      nonempty_r   <= {(PORT_NUM*VC_NUM){1'b0}};
      error_r      <= {PORT_NUM{1'b0}};
    end else begin
      for (int p = 0; p < PORT_NUM; p++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          if (push_do_s[p][v]) begin
            wr_ptr_r[p][v] <= ptr_inc(wr_ptr_r[p][v]);
          end
          if (pop_do_s[p][v]) begin
            rd_ptr_r[p][v] <= ptr_inc(rd_ptr_r[p][v]);
          end
          cnt_r[p][v]              <= cnt_next_s[p][v];
          nonempty_r[p*VC_NUM + v] <= (cnt_next_s[p][v] != {CNT_W{1'b0}});
        end
        if (pop_any_s[p]) begin
          flit_r[p*FLIT_W +: FLIT_W]  <= head_s[p];
          flit_valid_r[p]             <= 1'b1;
          credit_r[p]                 <= 1'b1;
          credit_vc_r[p*VC_W +: VC_W] <= pop_vc_s[p];
        end else begin
          flit_valid_r[p] <= 1'b0;
          credit_r[p]     <= 1'b0;
        end
        error_r[p] <= error_r[p] | err_s[p];
      end
    end
  end

  assign flit_o       = flit_r;
  assign flit_valid_o = flit_valid_r;
  assign credit_o     = credit_r;
  assign credit_vc_o  = credit_vc_r;
  assign nonempty_o   = nonempty_r;
  assign error_o      = error_r;

`ifdef VC_INPUT_BLOCK_OCC_EN
  // Expose the registered per-VC counts as a flat occupancy vector.
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        occ_o[(p*VC_NUM + v)*CNT_W +: CNT_W] = cnt_r[p][v];
      end
    end
  end
`endif

endmodule

// File: tb/tb_vc_input_block.sv
// Directed + table-driven bench for vc_input_block (default parameters).
module tb_vc_input_block;

  localparam int P = 5;
  localparam int V = 2;
  localparam int D = 8;
  localparam int FW = 32;
  localparam int CW = 4;

  logic            clk;
  logic            rst;
  logic [P*FW-1:0] data_i;
  logic [P-1:0]    valid_i;
  logic [P-1:0]    vc_i;
  logic [P-1:0]    rd_en_i;
  logic [P-1:0]    rd_vc_i;
  logic [P*FW-1:0] flit_o;
  logic [P-1:0]    flit_valid_o;
  logic [P-1:0]    credit_o;
  logic [P-1:0]    credit_vc_o;
  logic [P*V-1:0]  nonempty_o;
  logic [P-1:0]    error_o;
`ifdef VC_INPUT_BLOCK_OCC_EN
  logic [P*V*CW-1:0] occ_o;
`endif

  vc_input_block dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .vc_i(vc_i),
    .rd_en_i(rd_en_i), .rd_vc_i(rd_vc_i), .flit_o(flit_o), .flit_valid_o(flit_valid_o),
    .credit_o(credit_o), .credit_vc_o(credit_vc_o), .nonempty_o(nonempty_o),
    .error_o(error_o)
`ifdef VC_INPUT_BLOCK_OCC_EN
    , .occ_o(occ_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          port;
    logic        push;
    logic        push_vc;
    logic [31:0] data;
    logic        pop;
    logic        pop_vc;
    logic        e_valid;
    logic [31:0] e_flit;
    logic        e_cvc;
    logic [1:0]  e_nonempty;
    logic        e_err;
  } vec_t;

  vec_t vecs [11];

  // stress model
  logic [31:0] m_mem [P][V][D];
  int          m_head [P][V];
  int          m_cnt  [P][V];
  logic [31:0] m_last [P];
  logic        s_pop  [P];
  logic        s_push [P];
  int          s_pvc  [P];
  int          s_wvc  [P];
  logic [31:0] s_data [P];
  logic [31:0] s_exp  [P];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_i = '0; rd_en_i = '0; data_i = '0; vc_i = '0; rd_vc_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input int p, input logic vc, input logic [31:0] d);
    valid_i[p] = 1'b1; vc_i[p] = vc; data_i[p*FW +: FW] = d;
  endtask

  task automatic drive_pop(input int p, input logic vc);
    rd_en_i[p] = 1'b1; rd_vc_i[p] = vc;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_flit"}, 64'(flit_o == '0), 64'd1);
    chk({tag, "_valid"}, 64'(flit_valid_o), 64'd0);
    chk({tag, "_credit"}, 64'(credit_o), 64'd0);
    chk({tag, "_credit_vc"}, 64'(credit_vc_o), 64'd0);
    chk({tag, "_nonempty"}, 64'(nonempty_o), 64'd0);
    chk({tag, "_error"}, 64'(error_o), 64'd0);
`ifdef VC_INPUT_BLOCK_OCC_EN
    chk({tag, "_occ"}, 64'(occ_o == '0), 64'd1);
`endif
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    tick(); tick();
    chk_reset_state("reset");
    rst = 1'b1;

    //           port push vc data           pop vc  valid flit          cvc  ne     err
    vecs[0]  = '{0, 1'b1, 1'b1, 32'hA5A50001, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 2'b10, 1'b0};
    vecs[1]  = '{0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hA5A50001,  1'b1, 2'b00, 1'b0};
    vecs[2]  = '{0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hA5A50001,  1'b0, 2'b00, 1'b0};
    vecs[3]  = '{0, 1'b1, 1'b0, 32'h11,       1'b0, 1'b0, 1'b0, 32'hA5A50001,  1'b0, 2'b01, 1'b0};
    vecs[4]  = '{0, 1'b1, 1'b1, 32'h22,       1'b1, 1'b0, 1'b1, 32'h11,        1'b0, 2'b10, 1'b0};
    vecs[5]  = '{0, 1'b1, 1'b1, 32'h33,       1'b1, 1'b1, 1'b1, 32'h22,        1'b1, 2'b10, 1'b0};
    vecs[6]  = '{0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h33,        1'b1, 2'b00, 1'b0};
    vecs[7]  = '{1, 1'b1, 1'b0, 32'h44,       1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 2'b01, 1'b1};
    vecs[8]  = '{1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h44,        1'b0, 2'b00, 1'b1};
    vecs[9]  = '{4, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 2'b00, 1'b1};
    vecs[10] = '{4, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 2'b00, 1'b1};

    for (int i = 0; i < 11; i++) begin
      int p;
      p = vecs[i].port;
      idle_inputs();
      if (vecs[i].push) drive_push(p, vecs[i].push_vc, vecs[i].data);
      if (vecs[i].pop)  drive_pop(p, vecs[i].pop_vc);
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(flit_valid_o[p]), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d_credit", i), 64'(credit_o[p]), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d_flit", i), 64'(flit_o[p*FW +: FW]), 64'(vecs[i].e_flit));
      if (vecs[i].e_valid) chk($sformatf("vec%0d_cvc", i), 64'(credit_vc_o[p]), 64'(vecs[i].e_cvc));
      chk($sformatf("vec%0d_nonempty", i), 64'(nonempty_o[p*V +: V]), 64'(vecs[i].e_nonempty));
      chk($sformatf("vec%0d_err", i), 64'(error_o[p]), 64'(vecs[i].e_err));
    end
    idle_inputs();
    chk("port0_err_clean", 64'(error_o[0]), 64'd0);

    // Port 2: fill VC0, overflow, drain in order
    for (int i = 0; i < 8; i++) begin
      idle_inputs(); drive_push(2, 1'b0, 32'(i)); tick();
      chk("fill2_nonempty", 64'(nonempty_o[4]), 64'd1);
      chk("fill2_err", 64'(error_o[2]), 64'd0);
    end
    idle_inputs(); drive_push(2, 1'b0, 32'd8); tick();
    chk("overflow2_err", 64'(error_o[2]), 64'd1);
`ifdef VC_INPUT_BLOCK_OCC_EN
    chk("overflow2_occ", 64'(occ_o[4*CW +: CW]), 64'd8);
`endif
    for (int i = 0; i < 8; i++) begin
      idle_inputs(); drive_pop(2, 1'b0); tick();
      chk("drain2_valid", 64'(flit_valid_o[2]), 64'd1);
      chk("drain2_credit", 64'(credit_o[2]), 64'd1);
      chk("drain2_flit", 64'(flit_o[2*FW +: FW]), 64'(i));
    end
    idle_inputs(); tick();
    chk("drain2_empty", 64'(nonempty_o[4]), 64'd0);
    chk("drain2_valid_off", 64'(flit_valid_o[2]), 64'd0);

    // Port 3: full VC, simultaneous push+pop
    for (int i = 0; i < 8; i++) begin
      idle_inputs(); drive_push(3, 1'b0, 32'(i)); tick();
    end
    idle_inputs(); drive_push(3, 1'b0, 32'h99); drive_pop(3, 1'b0); tick();
    chk("fullpp3_flit", 64'(flit_o[3*FW +: FW]), 64'd0);
    chk("fullpp3_valid", 64'(flit_valid_o[3]), 64'd1);
    chk("fullpp3_err", 64'(error_o[3]), 64'd0);
`ifdef VC_INPUT_BLOCK_OCC_EN
    chk("fullpp3_occ", 64'(occ_o[6*CW +: CW]), 64'd8);
`endif
    for (int i = 1; i <= 8; i++) begin
      idle_inputs(); drive_pop(3, 1'b0); tick();
      chk("drain3_flit", 64'(flit_o[3*FW +: FW]), (i == 8) ? 64'h99 : 64'(i));
      chk("drain3_credit", 64'(credit_o[3]), 64'd1);
    end
    idle_inputs(); tick();
    chk("drain3_empty", 64'(nonempty_o[6]), 64'd0);
    chk("drain3_err", 64'(error_o[3]), 64'd0);

    // reset clears sticky errors
    rst = 1'b0; tick();
    chk_reset_state("reset2");
    rst = 1'b1;

    // Random legal traffic on all ports against a per-VC model
    for (int p = 0; p < P; p++) begin
      m_last[p] = 32'h0;
      for (int v = 0; v < V; v++) begin m_head[p][v] = 0; m_cnt[p][v] = 0; end
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      idle_inputs();
      for (int p = 0; p < P; p++) begin
        s_pvc[p]  = int'($urandom_range(0, 1));
        s_pop[p]  = ($urandom_range(0, 1) == 1) && (m_cnt[p][s_pvc[p]] > 0);
        s_wvc[p]  = int'($urandom_range(0, 1));
        s_push[p] = ($urandom_range(0, 9) < 6) &&
                    ((m_cnt[p][s_wvc[p]] < D) || (s_pop[p] && (s_pvc[p] == s_wvc[p])));
        s_data[p] = (32'(p) << 24) | 32'(cyc);
        if (s_pop[p])  drive_pop(p, 1'(s_pvc[p]));
        if (s_push[p]) drive_push(p, 1'(s_wvc[p]), s_data[p]);
      end
      tick();
      for (int p = 0; p < P; p++) begin
        if (s_pop[p]) begin
          s_exp[p] = m_mem[p][s_pvc[p]][m_head[p][s_pvc[p]]];
          m_head[p][s_pvc[p]] = (m_head[p][s_pvc[p]] + 1) % D;
          m_cnt[p][s_pvc[p]]--;
          m_last[p] = s_exp[p];
        end
        if (s_push[p]) begin
          m_mem[p][s_wvc[p]][(m_head[p][s_wvc[p]] + m_cnt[p][s_wvc[p]]) % D] = s_data[p];
          m_cnt[p][s_wvc[p]]++;
        end
        chk("rnd_valid", 64'(flit_valid_o[p]), 64'(s_pop[p]));
        chk("rnd_credit", 64'(credit_o[p]), 64'(s_pop[p]));
        chk("rnd_flit", 64'(flit_o[p*FW +: FW]), 64'(m_last[p]));
        if (s_pop[p]) chk("rnd_cvc", 64'(credit_vc_o[p]), 64'(s_pvc[p]));
        for (int v = 0; v < V; v++) begin
          chk("rnd_nonempty", 64'(nonempty_o[p*V + v]), 64'(m_cnt[p][v] != 0));
`ifdef VC_INPUT_BLOCK_OCC_EN
          chk("rnd_occ", 64'(occ_o[(p*V + v)*CW +: CW]), 64'(m_cnt[p][v]));
`endif
        end
      end
    end
    idle_inputs();
    chk("rnd_err", 64'(error_o), 64'd0);

    // Mid-stream reset: buffered flits discarded, no credits
    idle_inputs(); drive_push(0, 1'b0, 32'hDEAD0001); tick();
    chk("mid_prefill", 64'(nonempty_o[0]), 64'd1);
    idle_inputs(); rst = 1'b0; tick();
    chk_reset_state("midrst");
    rst = 1'b1; tick();
    chk("midrst_nocredit", 64'(credit_o), 64'd0);
    chk("midrst_empty", 64'(nonempty_o), 64'd0);
    drive_push(0, 1'b0, 32'h77); tick();
    chk("fresh_nonempty", 64'(nonempty_o[1:0]), 64'd1);
    idle_inputs(); drive_pop(0, 1'b0); tick();
    chk("fresh_flit", 64'(flit_o[FW-1:0]), 64'h77);
    chk("fresh_valid", 64'(flit_valid_o[0]), 64'd1);
    idle_inputs(); tick();
    chk("fresh_empty", 64'(nonempty_o), 64'd0);
    chk("fresh_err", 64'(error_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
